// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: write-op encoding and address sizing.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_CLEAR = 2'b11
  } wr_op_e;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Address width for a bank of 'depth' entries; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One bank entry: register plus its load/inc/dec/clear next-value logic.
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  wr_op_e           op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_hit
);

  logic [WIDTH-1:0] r_q;

  // Next value for the selected op, computed every cycle so the bank can bypass it.
  always_comb begin
    // NOTE: default assigned first so no branch can leave nxt unassigned and infer a latch.
    nxt = '0;
    unique case (op)
      OP_LOAD:  nxt = din;
      OP_INC:   nxt = r_q + WIDTH'(1);
      OP_DEC:   nxt = r_q - WIDTH'(1);
      OP_CLEAR: nxt = '0;
      default:  nxt = '0;
    endcase
  end

  assign wrap_hit = en && (((op == OP_INC) && (&r_q)) || ((op == OP_DEC) && !(|r_q)));

  // Storage update: reset wins over any write; otherwise take nxt when enabled.
  always_ff @(posedge clk) begin
    // NOTE: every entry is reset (not just control state) because reads must return 0 after reset.
    // NOTE: non-blocking assignment so all entries update from pre-edge values.
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= nxt;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/reg_bank.sv
// Bank of DEPTH registers with one op-select write port, two combinational
// read ports (optional write-to-read bypass) and a registered wrap pulse.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_op,
  input  logic [addr_width(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [addr_width(DEPTH)-1:0]  rd_addr_a,
  output logic [WIDTH-1:0]              rd_data_a,
  input  logic [addr_width(DEPTH)-1:0]  rd_addr_b,
  output logic [WIDTH-1:0]              rd_data_b,
  output logic                          wrap
);

  localparam int AW = addr_width(DEPTH);

  wr_op_e           w_op;
  logic [DEPTH-1:0] w_wr_sel;
  logic [DEPTH-1:0] w_wrap_hit;
  logic [WIDTH-1:0] w_q   [DEPTH];
  logic [WIDTH-1:0] w_nxt [DEPTH];
  logic [WIDTH-1:0] w_nxt_sel;
  logic             w_wr_hit;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             r_wrap;

  assign w_op = wr_op_e'(wr_op);

  // Entries with decoded write enables; an out-of-range wr_addr selects none.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    assign w_wr_sel[g] = wr_en && (wr_addr == AW'(g));

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (w_wr_sel[g]),
      .op       (w_op),
      .din      (wr_data),
      .q        (w_q[g]),
      .nxt      (w_nxt[g]),
      .wrap_hit (w_wrap_hit[g])
    );
  end

  assign w_wr_hit = |w_wr_sel;

  // Next value of the entry being written (zero when nothing in range is written).
  always_comb begin
    w_nxt_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt_sel = w_nxt_sel | (w_nxt[i] & {WIDTH{w_wr_sel[i]}});
    end
  end

  // Read muxes: stored value (0 when out of range), overridden by bypass data.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == AW'(i)) w_rd_a = w_q[i];
      if (rd_addr_b == AW'(i)) w_rd_b = w_q[i];
    end
    if ((BYPASS != 0) && rst_n && w_wr_hit) begin
      if (rd_addr_a == wr_addr) w_rd_a = w_nxt_sel;
      if (rd_addr_b == wr_addr) w_rd_b = w_nxt_sel;
    end
  end

  assign rd_data_a = w_rd_a;
  assign rd_data_b = w_rd_b;

  // One-cycle wrap pulse for each wrapping INC/DEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= |w_wrap_hit;
    end
  end

  assign wrap = r_wrap;

endmodule
